// File: rtl/cpu_top.sv
// cpu_top: 8-bit accumulator CPU with a unified 256x8 memory.
// Define CPU_DEBUG_PORTS_EN to expose PC and ACC on opc/oacc.
package cpu_pkg;
   localparam int pDATA_WIDTH = 8;
   localparam int pMEM_DEPTH  = 2**pDATA_WIDTH;
endpackage

module cpu_mem
   import cpu_pkg::*;
(
   input  logic                   iclk,
   input  logic                   ien,
   input  logic                   iwe,
   input  logic [pDATA_WIDTH-1:0] iaddr,
   input  logic [pDATA_WIDTH-1:0] iwdata,
   output logic [pDATA_WIDTH-1:0] ordata
);
   logic [pMEM_DEPTH-1:0][pDATA_WIDTH-1:0] rmemory_array;
   // holding the read word while disabled gives a stalled state the same data on resume
   always_ff @(posedge iclk)
      if (ien) begin
         if (iwe) rmemory_array[iaddr] <= iwdata;
         ordata <= rmemory_array[iaddr];
      end
endmodule

module cpu_top
   import cpu_pkg::*;
(
   input  logic                   iclk,
   input  logic                   irst_n,
   input  logic                   ien,
   output logic                   ohalt
`ifdef CPU_DEBUG_PORTS_EN
   ,
   output logic [pDATA_WIDTH-1:0] opc,
   output logic [pDATA_WIDTH-1:0] oacc
`endif
);
   typedef logic [pDATA_WIDTH-1:0] word_t;
   typedef enum logic [2:0] {S_IF, S_ID, S_AD, S_RD, S_EX, S_HALT} state_t;
   localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
                          OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6;
   state_t     state, state_nx;
   word_t      pc, pc_nx, ar, ar_nx, acc, acc_nx, addr, rdata;
   logic [2:0] ir, ir_nx;
   logic       we;

   // reset gates the memory so an STO caught by reset in EX never commits
   cpu_mem u_mem (
      .iclk   (iclk),
      .ien    (ien & irst_n),
      .iwe    (we),
      .iaddr  (addr),
      .iwdata (acc),
      .ordata (rdata)
   );

   always_ff @(posedge iclk)
      if (!irst_n) begin
         state <= S_IF;
         pc    <= '0;
         ir    <= '0;
         ar    <= '0;
         acc   <= '0;
      end else if (ien) begin
         state <= state_nx;
         pc    <= pc_nx;
         ir    <= ir_nx;
         ar    <= ar_nx;
         acc   <= acc_nx;
      end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      ir_nx    = ir;
      ar_nx    = ar;
      acc_nx   = acc;
      addr     = pc;
      we       = 1'b0;
      case (state)
         S_IF: state_nx = S_ID;
         S_ID: begin
            ir_nx    = rdata[pDATA_WIDTH-1 -: 3];
            addr     = pc + word_t'(1);
            state_nx = S_AD;
         end
         S_AD: begin
            ar_nx    = rdata;
            state_nx = S_RD;
         end
         S_RD: begin
            addr     = ar;
            state_nx = S_EX;
         end
         S_EX: begin
            addr     = ar;
            pc_nx    = pc + word_t'(2);
            state_nx = S_IF;
            case (ir)
               OP_HLT: begin
                  pc_nx    = pc;
                  state_nx = S_HALT;
               end
               OP_SKZ: pc_nx = pc + ((acc == '0) ? word_t'(4) : word_t'(2));
               OP_ADD: acc_nx = acc + rdata;
               OP_AND: acc_nx = acc & rdata;
               OP_XOR: acc_nx = acc ^ rdata;
               OP_LDA: acc_nx = rdata;
               OP_STO: we = 1'b1;
               default: pc_nx = ar;
            endcase
         end
         default: state_nx = S_HALT;
      endcase
   end

   assign ohalt = state == S_HALT;
`ifdef CPU_DEBUG_PORTS_EN
   assign opc  = pc;
   assign oacc = acc;
`endif
endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: scoreboard bench for cpu_top; expectations come from an ISA-level model and hand constants.
module tb_cpu_top;
   typedef logic [255:0][7:0] image_t;
   typedef struct {string tag; int sel; int addr; logic [31:0] val;} exp_t;

   logic iclk = 1'b0, irst_n = 1'b0, ien = 1'b0, ohalt;
`ifdef CPU_DEBUG_PORTS_EN
   logic [7:0] opc, oacc;
`endif

   cpu_top dut (
      .iclk   (iclk),
      .irst_n (irst_n),
      .ien    (ien),
      .ohalt  (ohalt)
`ifdef CPU_DEBUG_PORTS_EN
      ,
      .opc    (opc),
      .oacc   (oacc)
`endif
   );

   always #5 iclk = ~iclk;

   exp_t   sb[$];
   int     n_err = 0, n_chk = 0, edges = 0;
   image_t img, exp_mem;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] observe(input int sel, input int addr);
      int diffs = 0;
      case (sel)
`ifdef CPU_DEBUG_PORTS_EN
         0: return 32'(opc);
         1: return 32'(oacc);
`else
         0: return 32'(dut.pc);
         1: return 32'(dut.acc);
`endif
         2: return 32'(dut.u_mem.rmemory_array[addr]);
         3: return 32'(edges);
         4: return 32'(ohalt);
         5: begin
            for (int i = 0; i < 256; i++)
               if (dut.u_mem.rmemory_array[i] !== exp_mem[i]) diffs++;
            return 32'(diffs);
         end
         default: return 32'(dut.state);
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input int addr, input logic [31:0] val);
      sb.push_back('{tag, sel, addr, val});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.sel, e.addr), e.val);
      end
   endtask

   // instruction-level reference: 5 cycles per instruction, 8-bit wrapping PC and operand fetch
   task automatic model(input image_t im, output logic [7:0] mpc, output logic [7:0] macc,
                        output int mcyc, output image_t mm);
      logic [7:0] nxt, opnd;
      logic [2:0] op;
      bit done = 0;
      mpc = 0; macc = 0; mcyc = 0; mm = im;
      for (int i = 0; i < 100 && !done; i++) begin
         nxt  = mpc + 8'd1;
         op   = mm[mpc][7:5];
         opnd = mm[nxt];
         mcyc += 5;
         case (op)
            3'd0: done = 1;
            3'd1: mpc = mpc + ((macc == 8'd0) ? 8'd4 : 8'd2);
            3'd2: begin macc = macc + mm[opnd]; mpc = mpc + 8'd2; end
            3'd3: begin macc = macc & mm[opnd]; mpc = mpc + 8'd2; end
            3'd4: begin macc = macc ^ mm[opnd]; mpc = mpc + 8'd2; end
            3'd5: begin macc = mm[opnd];        mpc = mpc + 8'd2; end
            3'd6: begin mm[opnd] = macc;        mpc = mpc + 8'd2; end
            default: mpc = opnd;
         endcase
      end
   endtask

   task load(input image_t im);
      irst_n = 1'b0;
      ien    = 1'b0;
      img    = im;
      force dut.u_mem.rmemory_array = img;
      repeat (5) @(negedge iclk);
      release dut.u_mem.rmemory_array;
      @(negedge iclk);
   endtask

   // mask bit k: insert a 3-cycle ien=0 stall before active cycle k
   task automatic run(input logic [63:0] mask);
      int cyc = 0, pend = 0, last = -1;
      irst_n = 1'b1;
      edges  = 0;
      while (!ohalt && edges < 2000) begin
         if (pend == 0 && cyc < 64 && mask[cyc] && last != cyc) begin
            pend = 3;
            last = cyc;
         end
         ien = (pend == 0);
         if (pend > 0) pend--;
         @(negedge iclk);
         edges++;
         if (ien) cyc++;
      end
      ien = 1'b0;
      chk("halt_reached", 32'(ohalt), 1);
   endtask

   task automatic scenario(input string tag, input image_t im, input bit do_load,
                           input logic [63:0] mask, input int nst,
                           input logic [7:0] k_pc, input logic [7:0] k_acc);
      logic [7:0] mpc, macc;
      int mcyc;
      image_t mm;
      model(im, mpc, macc, mcyc, mm);
      exp_mem = mm;
      push({tag, "_pc"}, 0, 0, 32'(mpc));
      push({tag, "_acc"}, 1, 0, 32'(macc));
      push({tag, "_cycles"}, 3, 0, 32'(mcyc + 3 * nst));
      push({tag, "_memdiff"}, 5, 0, 0);
      push({tag, "_pc_k"}, 0, 0, 32'(k_pc));
      push({tag, "_acc_k"}, 1, 0, 32'(k_acc));
      if (do_load) load(im);
      run(mask);
      drain();
   endtask

   initial begin
      image_t p;
      // LDA 10; ADD 11; STO 12; HLT
      p = '0;
      p[0] = 8'hA0; p[1] = 8'h10; p[2] = 8'h40; p[3] = 8'h11; p[4] = 8'hC0; p[5] = 8'h12;
      p[8'h10] = 8'h7F; p[8'h11] = 8'h85;
      load(p);
      push("rst_halt", 4, 0, 0);
      push("rst_pc", 0, 0, 0);
      push("rst_acc", 1, 0, 0);
      push("rst_state", 6, 0, 0);
      drain();
      irst_n = 1'b1;
      ien    = 1'b0;
      repeat (20) @(negedge iclk);
      exp_mem = p;
      push("frz_pc", 0, 0, 0);
      push("frz_halt", 4, 0, 0);
      push("frz_state", 6, 0, 0);
      push("frz_memdiff", 5, 0, 0);
      drain();

      push("p1_mem12", 2, 8'h12, 8'h04);
      push("p1_cycles_k", 3, 0, 20);
      scenario("p1", p, 1, 64'h0, 0, 8'h06, 8'h04);
      push("stall_mem12", 2, 8'h12, 8'h04);
      scenario("stall", p, 1, 64'h3E0, 5, 8'h06, 8'h04);

      // reset during EX of STO 12 drops the write, then the program re-runs from 0
      p[8'h12] = 8'h55;
      load(p);
      irst_n = 1'b1;
      ien    = 1'b1;
      repeat (14) @(negedge iclk);
      push("mid_state_ex", 6, 0, 4);
      drain();
      irst_n = 1'b0;
      @(negedge iclk);
      ien = 1'b0;
      push("mid_mem12", 2, 8'h12, 8'h55);
      push("mid_pc", 0, 0, 0);
      push("mid_acc", 1, 0, 0);
      push("mid_halt", 4, 0, 0);
      drain();
      push("rerun_mem12", 2, 8'h12, 8'h04);
      scenario("rerun", p, 0, 64'h0, 0, 8'h06, 8'h04);

      // LDA F0; AND 3C; XOR FF
      p = '0;
      p[0] = 8'hA0; p[1] = 8'h10; p[2] = 8'h60; p[3] = 8'h11; p[4] = 8'h80; p[5] = 8'h12;
      p[8'h10] = 8'hF0; p[8'h11] = 8'h3C; p[8'h12] = 8'hFF;
      scenario("logic", p, 1, 64'h0, 0, 8'h06, 8'hCF);

      // LDA; SKZ; JMP 40; HLT, with ACC zero then nonzero
      p = '0;
      p[0] = 8'hA0; p[1] = 8'h10; p[2] = 8'h20; p[4] = 8'hE0; p[5] = 8'h40;
      scenario("skz_taken", p, 1, 64'h0, 0, 8'h06, 8'h00);
      p[8'h10] = 8'h01;
      scenario("jmp_taken", p, 1, 64'h0, 0, 8'h40, 8'h01);

      // PC wrap: LDA at FE lands on 00
      p = '0;
      p[0] = 8'h20; p[4] = 8'hE0; p[5] = 8'hFE; p[254] = 8'hA0; p[255] = 8'h20; p[8'h20] = 8'h01;
      scenario("pc_wrap", p, 1, 64'h0, 0, 8'h02, 8'h01);

      // operand wrap: instruction at FF takes its operand from 00
      p = '0;
      p[0] = 8'hE0; p[1] = 8'hFF; p[2] = 8'h30; p[255] = 8'hA0; p[8'hE0] = 8'h5A;
      scenario("opnd_wrap", p, 1, 64'h0, 0, 8'h30, 8'h5A);

      // STO then LDA/ADD of the same word
      p = '0;
      p[0] = 8'hA0; p[1] = 8'h10; p[2] = 8'hC0; p[3] = 8'h20; p[4] = 8'hA0; p[5] = 8'h20;
      p[6] = 8'h40; p[7] = 8'h20; p[8'h10] = 8'h3C;
      push("sto_lda_mem20", 2, 8'h20, 8'h3C);
      scenario("sto_lda", p, 1, 64'h0, 0, 8'h08, 8'h78);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
